mem_bus_arbiter: RTL

//  Shares one single-port synchronous memory bus (addr/data_in/data_out/write_en, 1-cycle registered read)

---
 rtl/mem_bus_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master req/ack arbiter onto one single-port synchronous memory bus, one transaction in flight.
// Ties are round-robin by default; define MEM_ARB_FIXED_PRIO_EN to give master 0 fixed priority.
module mem_bus_arbiter #(
  parameter int addr_size = 16,
  parameter int word_size = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [addr_size-1:0] addr0,
  input  logic [addr_size-1:0] addr1,
  input  logic [word_size-1:0] wdata0,
  input  logic [word_size-1:0] wdata1,
  input  logic                 we0,
  input  logic                 we1,
  output logic [word_size-1:0] rdata0,
  output logic [word_size-1:0] rdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [word_size-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [addr_size-1:0]  mem_addr_q, mem_addr_d;
  logic [word_size-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic [word_size-1:0]  rdata0_q, rdata0_d;
  logic [word_size-1:0]  rdata1_q, rdata1_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  elig0_s, elig1_s, pick1_s;

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_addr_q   <= {addr_size{1'b0}};
      mem_wdata_q  <= {word_size{1'b0}};
      mem_we_q     <= 1'b0;
      rdata0_q     <= {word_size{1'b0}};
      rdata1_q     <= {word_size{1'b0}};
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

  // Arbitration, next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;

    // A master being acked this cycle is not re-granted on the same edge.
    elig0_s = req0 & ~ack0_q;
    elig1_s = req1 & ~ack1_q;
`ifdef MEM_ARB_FIXED_PRIO_EN
    pick1_s = elig1_s & ~elig0_s;
`else
    pick1_s = elig1_s & (~elig0_s | ~last_grant_q);
`endif

    case (state_q)
      IDLE: begin
        if (elig0_s | elig1_s) begin
          owner_d      = pick1_s;
          last_grant_d = pick1_s;
          mem_addr_d   = pick1_s ? addr1 : addr0;
          mem_wdata_d  = pick1_s ? wdata1 : wdata0;
          mem_we_d     = pick1_s ? we1 : we0;
          state_d      = ISSUE;
        end else begin
          mem_addr_d  = {addr_size{1'b0}};
          mem_wdata_d = {word_size{1'b0}};
          mem_we_d    = 1'b0;
        end
      end
      ISSUE: begin
        mem_we_d = 1'b0;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        if (owner_q) begin
          rdata1_d = mem_rdata;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = mem_rdata;
          ack0_d   = 1'b1;
        end
        mem_addr_d  = {addr_size{1'b0}};
        mem_wdata_d = {word_size{1'b0}};
        mem_we_d    = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        mem_addr_d  = {addr_size{1'b0}};
        mem_wdata_d = {word_size{1'b0}};
        mem_we_d    = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule
